// File: rtl/map_port_arbiter_if.sv
// Shared map read port bundle: three requesters, one map ROM port, responses.
// The arbiter takes the slave side; the requesters/ROM environment takes master.
interface map_port_arbiter_if;
    logic [2:0]  req_valid;
    logic [29:0] req_col;
    logic [29:0] req_row;
    logic [2:0]  req_ready;
    logic [2:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic [9:0]  map_col_addr;
    logic [9:0]  map_row_addr;
    logic [7:0]  map_data;

    modport slave (
        input  req_valid, req_col, req_row, map_data,
        output req_ready, rsp_valid, rsp_data, map_col_addr, map_row_addr
    );

    modport master (
        output req_valid, req_col, req_row, map_data,
        input  req_ready, rsp_valid, rsp_data, map_col_addr, map_row_addr
    );
endinterface

// File: rtl/map_port_arbiter.sv
// Round-robin arbiter letting three requesters share one map ROM read port.
// One request is in flight at a time: accept, wait ROM_LATENCY edges for the
// ROM, capture the byte, and pulse rsp_valid for the granted requester.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | port free; req_ready offered to the round-robin winner
//   ST_WAIT    | address on the map port, counting down ROM latency
//   ST_CAPTURE | map_data valid; next edge registers it and pulses rsp_valid
module map_port_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int ROM_LATENCY = 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    map_port_arbiter_if.slave bus,
    output logic              busy_o
);

    localparam int CNT_W = (ROM_LATENCY < 2) ? 1 : $clog2(ROM_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t           state_q;
    logic [1:0]       rr_ptr_q;
    logic [1:0]       grant_q;
    logic [CNT_W-1:0] cnt_q;
    logic [9:0]       col_q;
    logic [9:0]       row_q;
    logic [7:0]       rsp_data_q;
    logic [2:0]       rsp_valid_q;

    logic             win_found;
    logic [1:0]       win_idx;
    logic [2:0]       cand;
    logic [9:0]       win_col;
    logic [9:0]       win_row;
    logic [1:0]       rr_ptr_d;

    // Scan requesters from rr_ptr upward (mod NUM_REQ); first valid one wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + 3'(k);
            if (cand >= 3'(NUM_REQ)) begin
                cand = cand - 3'(NUM_REQ);
            end
            if (!win_found && bus.req_valid[cand[1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[1:0];
            end
        end
    end

    // Winner's addresses and the pointer value that follows its grant.
    always_comb begin
        win_col  = bus.req_col[int'(win_idx) * 10 +: 10];
        win_row  = bus.req_row[int'(win_idx) * 10 +: 10];
        rr_ptr_d = (win_idx == 2'(NUM_REQ - 1)) ? 2'd0 : win_idx + 2'd1;
    end

    // Ready is only ever offered to the winner, so any handshake is an accept.
    assign bus.req_ready = (state_q == ST_IDLE && !reset_i && win_found)
                           ? (3'b001 << win_idx) : 3'b000;

    assign busy_o           = (state_q != ST_IDLE) && !reset_i;
    assign bus.map_col_addr = col_q;
    assign bus.map_row_addr = row_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_valid    = rsp_valid_q;

    // Sequencing FSM with registered map address and response outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= 2'd0;
            grant_q     <= 2'd0;
            cnt_q       <= '0;
            col_q       <= 10'd0;
            row_q       <= 10'd0;
            rsp_data_q  <= 8'd0;
            rsp_valid_q <= 3'b000;
        end else begin
            rsp_valid_q <= 3'b000;
            case (state_q)
                ST_IDLE: begin
                    if (win_found) begin
                        col_q    <= win_col;
                        row_q    <= win_row;
                        grant_q  <= win_idx;
                        rr_ptr_q <= rr_ptr_d;
                        cnt_q    <= CNT_W'(ROM_LATENCY);
                        state_q  <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    // Leaving on the edge where the count hits zero (<= 1 also
                    // keeps a zero latency build from wrapping).
                    if (cnt_q <= CNT_W'(1)) begin
                        state_q <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    rsp_data_q  <= bus.map_data;
                    rsp_valid_q <= 3'b001 << grant_q;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_map_port_arbiter.sv
// Bench for map_port_arbiter: a ROM_LATENCY=1 instance driven from a vector
// table plus hand-written sequences, and a ROM_LATENCY=2 instance for timing.
module tb_map_port_arbiter;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy1, busy2;
    int   nvec = 0;
    int   nmis = 0;
    int   cyc  = 0;

    map_port_arbiter_if b1 ();
    map_port_arbiter_if b2 ();

    map_port_arbiter #(.NUM_REQ(3), .ROM_LATENCY(1)) dut1 (
        .clk_i(clk), .reset_i(reset), .bus(b1.slave), .busy_o(busy1));
    map_port_arbiter #(.NUM_REQ(3), .ROM_LATENCY(2)) dut2 (
        .clk_i(clk), .reset_i(reset), .bus(b2.slave), .busy_o(busy2));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom_f(input logic [9:0] c, input logic [9:0] r);
        return (c[7:0] ^ {r[4:0], r[9:7]}) + {4'h0, c[9:8], r[6:5]} + 8'h3C;
    endfunction

    // Map ROM models: one and two registered stages after the address.
    logic [7:0] rom1_q = 8'd0, rom2a_q = 8'd0, rom2b_q = 8'd0;
    always @(posedge clk) begin
        rom1_q  <= rom_f(b1.map_col_addr, b1.map_row_addr);
        rom2a_q <= rom_f(b2.map_col_addr, b2.map_row_addr);
        rom2b_q <= rom2a_q;
    end
    assign b1.map_data = rom1_q;
    assign b2.map_data = rom2b_q;

    typedef struct {
        logic [2:0]  valid;
        logic [2:0]  exp_ready;
        logic [29:0] col;
        logic [29:0] row;
    } vec_t;

    typedef struct {
        logic [2:0] rsp;
        logic [7:0] data;
        int         due;
    } exp_t;

    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Response monitor for the latency-1 instance.
    always @(negedge clk) begin
        if (!reset && b1.rsp_valid != 3'b000) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", {29'd0, b1.rsp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_valid", {29'd0, b1.rsp_valid}, {29'd0, e.rsp});
                chk("rsp_data", {24'd0, b1.rsp_data}, {24'd0, e.data});
                chk("rsp_cycle", cyc, e.due);
            end
        end
    end

    task automatic wait_idle1();
        for (int k = 0; k < 20 && busy1; k++) @(negedge clk);
        chk("idle_timeout", {31'd0, busy1}, 32'd0);
    endtask

    task automatic wait_sb();
        for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
        chk("rsp_missing", sb.size(), 32'd0);
    endtask

    function automatic int oh2idx(input logic [2:0] oh);
        return oh[2] ? 2 : (oh[1] ? 1 : 0);
    endfunction

    // One table transaction: offer, check grant, check address, await response.
    task automatic do_txn(input vec_t v);
        int idx;
        idx = oh2idx(v.exp_ready);
        wait_idle1();
        b1.req_valid = v.valid;
        b1.req_col   = v.col;
        b1.req_row   = v.row;
        #1;
        chk("req_ready", {29'd0, b1.req_ready}, {29'd0, v.exp_ready});
        if (v.exp_ready != 3'b000) begin
            sb.push_back('{v.exp_ready, rom_f(v.col[idx*10 +: 10], v.row[idx*10 +: 10]), cyc + 3});
            @(posedge clk);
            @(negedge clk);
            b1.req_valid = 3'b000;
            chk("map_col", {22'd0, b1.map_col_addr}, {22'd0, v.col[idx*10 +: 10]});
            chk("map_row", {22'd0, b1.map_row_addr}, {22'd0, v.row[idx*10 +: 10]});
            chk("busy_wait", {31'd0, busy1}, 32'd1);
            wait_sb();
        end else begin
            @(negedge clk);
        end
        b1.req_valid = 3'b000;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    vec_t vecs[12];
    int   acc[4];
    int   n0, busy_n, rsp_n, rsp_cyc;
    logic [7:0] rsp_d;
    logic [2:0] rsp_v;

    initial begin
        // Table: {valid, expected one-hot grant}, pointer tracked by hand.
        vecs[0].valid  = 3'b001; vecs[0].exp_ready  = 3'b001;
        vecs[1].valid  = 3'b000; vecs[1].exp_ready  = 3'b000;
        vecs[2].valid  = 3'b111; vecs[2].exp_ready  = 3'b010;
        vecs[3].valid  = 3'b111; vecs[3].exp_ready  = 3'b100;
        vecs[4].valid  = 3'b111; vecs[4].exp_ready  = 3'b001;
        vecs[5].valid  = 3'b101; vecs[5].exp_ready  = 3'b100;
        vecs[6].valid  = 3'b101; vecs[6].exp_ready  = 3'b001;
        vecs[7].valid  = 3'b010; vecs[7].exp_ready  = 3'b010;
        vecs[8].valid  = 3'b011; vecs[8].exp_ready  = 3'b001;
        vecs[9].valid  = 3'b110; vecs[9].exp_ready  = 3'b010;
        vecs[10].valid = 3'b100; vecs[10].exp_ready = 3'b100;
        vecs[11].valid = 3'b010; vecs[11].exp_ready = 3'b010;
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 3; i++) begin
                vecs[k].col[i*10 +: 10] = 10'((k * 97 + i * 211 + 5) % 1024);
                vecs[k].row[i*10 +: 10] = 10'((k * 53 + i * 131 + 17) % 1024);
            end
        end
        vecs[0].col[9:0]    = 10'd10;
        vecs[0].row[9:0]    = 10'd20;
        vecs[10].col[29:20] = 10'd1023;
        vecs[10].row[29:20] = 10'd1023;

        b1.req_valid = 3'b111; b1.req_col = '0; b1.req_row = '0;
        b2.req_valid = 3'b000; b2.req_col = '0; b2.req_row = '0;

        // Reset: nothing offered while reset is high, everything cleared after.
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_ready", {29'd0, b1.req_ready}, 32'd0);
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        reset = 1'b0;
        b1.req_valid = 3'b000;
        #1;
        chk("rst_map_col", {22'd0, b1.map_col_addr}, 32'd0);
        chk("rst_map_row", {22'd0, b1.map_row_addr}, 32'd0);
        chk("rst_rsp_valid", {29'd0, b1.rsp_valid}, 32'd0);
        chk("rst_rsp_data", {24'd0, b1.rsp_data}, 32'd0);
        chk("rst_busy2", {31'd0, busy2}, 32'd0);

        for (int k = 0; k < 12; k++) do_txn(vecs[k]);

        // All requesters held: grants 0,1,2,0 spaced three cycles apart.
        pulse_reset();
        b1.req_valid = 3'b111;
        for (int g = 0; g < 4; g++) begin
            wait_idle1();
            #1;
            chk("contend_ready", {29'd0, b1.req_ready}, 32'd1 << (g % 3));
            sb.push_back('{3'b001 << (g % 3),
                           rom_f(b1.req_col[(g % 3)*10 +: 10], b1.req_row[(g % 3)*10 +: 10]),
                           cyc + 3});
            acc[g] = cyc;
            @(posedge clk);
            @(negedge clk);
        end
        b1.req_valid = 3'b000;
        wait_sb();
        for (int g = 0; g < 3; g++) chk("contend_spacing", acc[g+1] - acc[g], 32'd3);

        // Requester 1 pulses only while busy: never granted, pointer untouched.
        wait_idle1();
        b1.req_valid = 3'b001;
        #1;
        chk("wd_ready0", {29'd0, b1.req_ready}, 32'd1);
        sb.push_back('{3'b001, rom_f(b1.req_col[9:0], b1.req_row[9:0]), cyc + 3});
        @(posedge clk);
        @(negedge clk);
        b1.req_valid = 3'b010;
        #1;
        chk("wd_ready_wait", {29'd0, b1.req_ready}, 32'd0);
        @(negedge clk);
        b1.req_valid = 3'b000;
        wait_sb();
        wait_idle1();
        b1.req_valid = 3'b111;
        #1;
        chk("wd_ptr", {29'd0, b1.req_ready}, 32'd2);
        sb.push_back('{3'b010, rom_f(b1.req_col[19:10], b1.req_row[19:10]), cyc + 3});
        @(posedge clk);
        @(negedge clk);
        b1.req_valid = 3'b000;
        wait_sb();

        // Reset while waiting on the ROM aborts the request silently.
        wait_idle1();
        b1.req_valid = 3'b100;
        #1;
        chk("abort_ready", {29'd0, b1.req_ready}, 32'd4);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        b1.req_valid = 3'b111;
        #1;
        chk("abort_busy_rst", {31'd0, busy1}, 32'd0);
        chk("abort_ready_rst", {29'd0, b1.req_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        b1.req_valid = 3'b000;
        #1;
        chk("abort_busy", {31'd0, busy1}, 32'd0);
        chk("abort_map_col", {22'd0, b1.map_col_addr}, 32'd0);
        chk("abort_map_row", {22'd0, b1.map_row_addr}, 32'd0);
        chk("abort_rsp_data", {24'd0, b1.rsp_data}, 32'd0);
        repeat (4) @(negedge clk);
        b1.req_valid = 3'b111;
        #1;
        chk("abort_ptr", {29'd0, b1.req_ready}, 32'd1);
        sb.push_back('{3'b001, rom_f(b1.req_col[9:0], b1.req_row[9:0]), cyc + 3});
        @(posedge clk);
        @(negedge clk);
        b1.req_valid = 3'b000;
        wait_sb();

        // Latency-2 instance: response three edges after accept, busy 3 cycles.
        b2.req_valid = 3'b001;
        b2.req_col   = {20'd0, 10'd300};
        b2.req_row   = {20'd0, 10'd700};
        #1;
        chk("l2_ready", {29'd0, b2.req_ready}, 32'd1);
        n0 = cyc;
        @(posedge clk);
        @(negedge clk);
        b2.req_valid = 3'b000;
        chk("l2_map_col", {22'd0, b2.map_col_addr}, 32'd300);
        chk("l2_map_row", {22'd0, b2.map_row_addr}, 32'd700);
        busy_n = 0; rsp_n = 0; rsp_cyc = -1; rsp_d = 8'd0; rsp_v = 3'b000;
        for (int k = 0; k < 8; k++) begin
            if (busy2) busy_n++;
            if (b2.rsp_valid != 3'b000) begin
                rsp_n++;
                rsp_cyc = cyc;
                rsp_d   = b2.rsp_data;
                rsp_v   = b2.rsp_valid;
            end
            @(negedge clk);
        end
        chk("l2_busy_cycles", busy_n, 32'd3);
        chk("l2_rsp_count", rsp_n, 32'd1);
        chk("l2_rsp_cycle", rsp_cyc, n0 + 4);
        chk("l2_rsp_valid", {29'd0, rsp_v}, 32'd1);
        chk("l2_rsp_data", {24'd0, rsp_d}, {24'd0, rom_f(10'd300, 10'd700)});

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not complete by cycle %0d", cyc);
        $fatal(1);
    end

endmodule

// File: doc/map_port_arbiter.md
MAP_PORT_ARBITER -- requirements
Module: map_port_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 3, meaning the number of requesters sharing one map read port (fixed at 3 for this release).
REQ-002 The block SHALL have parameter ROM_LATENCY, default 1, meaning the number of clock edges from map address change to valid map data.
REQ-003 clk  input  1  rising-edge clock, shared with map ROM.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req_valid  input  3  per-requester read request, bit i = requester i.
REQ-006 req_col  input  30  packed column addresses, requester i at [10i+9:10i].
REQ-007 req_row  input  30  packed row addresses, requester i at [10i+9:10i].
REQ-008 req_ready  output  3  one-hot accept strobe; request i accepted on an edge where req_valid[i] and req_ready[i] are both high.
REQ-009 rsp_valid  output  3  one-hot, one-cycle pulse marking rsp_data valid for requester i.
REQ-010 rsp_data  output  8  map tile byte returned for the accepted request.
REQ-011 map_col_addr  output  10  column address driven to the map port.
REQ-012 map_row_addr  output  10  row address driven to the map port.
REQ-013 map_data  input  8  map port read data.
REQ-014 busy  output  1  high whenever state is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and CAPTURE.
REQ-016 In IDLE with any req_valid high, req_ready SHALL be asserted combinationally on exactly one bit, the winner; otherwise req_ready = 0.
REQ-017 Winner selection SHALL be round-robin: the first requester with req_valid high scanning from rr_ptr upward, modulo 3.
REQ-018 On the accept edge, map_col_addr/map_row_addr SHALL register the winner's addresses unmodified, grant index SHALL be stored, rr_ptr SHALL become (winner+1) mod 3, a latency counter SHALL load ROM_LATENCY, and the FSM SHALL enter WAIT.
REQ-019 In WAIT the counter SHALL decrement each edge; on the edge where it reaches 0 (i.e. ROM_LATENCY edges after accept) the FSM SHALL enter CAPTURE.
REQ-020 In CAPTURE, on the next edge rsp_data SHALL register map_data, rsp_valid[grant] SHALL be set for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-021 End-to-end: rsp_valid SHALL be high in the cycle following edge E0+ROM_LATENCY+1, where E0 is the accept edge; throughput one request per ROM_LATENCY+2 cycles.
REQ-022 req_ready SHALL be 0 in WAIT and CAPTURE; a new grant is possible in the IDLE cycle in which rsp_valid is high.
REQ-023 map_col_addr/map_row_addr SHALL hold their last value until the next accept edge; rsp_data SHALL hold until the next CAPTURE.
REQ-024 A requester dropping req_valid before acceptance SHALL not be granted and SHALL not move rr_ptr.
REQ-025 Addresses outside map bounds SHALL be passed through; out-of-range handling belongs to the map.
REQ-026 Simultaneous requests SHALL be served strictly in round-robin order; no requester SHALL wait more than 2 other grants while continuously requesting.

Reset
REQ-027 On reset high at a clock edge: state = IDLE, rr_ptr = 0, grant = 0, counter = 0, map addresses = 0, rsp_data = 0, rsp_valid = 0; req_ready and busy SHALL be 0 while reset is high.
REQ-028 Reset asserted mid-transaction SHALL abort it; no rsp_valid pulse SHALL be produced for the aborted request.

Verification
REQ-029 Single request: reset, req_valid=3'b001, col=10, row=20, ROM_LATENCY=1 -> req_ready=001 in first cycle, map addr (10,20) after accept, rsp_valid=001 two edges later with rsp_data = ROM byte at (10,20).
REQ-030 All-contend: req_valid=3'b111 held -> grant order 0,1,2,0; each rsp_valid pulse one cycle, 3 cycles apart.
REQ-031 Pointer skip: after grant 0, req_valid=3'b101 -> next grant is 2, then 0.
REQ-032 Withdrawn request: req_valid[1] pulsed only during WAIT -> no grant to 1, rr_ptr unchanged.
REQ-033 Reset mid-WAIT: reset one cycle during WAIT -> rsp_valid stays 0, busy=0, map addr=0, rr_ptr=0.
REQ-034 ROM_LATENCY=2 build: single request -> rsp_valid three edges after accept, busy high for exactly 3 cycles.
